// File: rtl/ucore_output_channels.sv
// Purpose: ucore output stage; buffers FU results in a small FIFO and eager-forks
//          each head word to every enabled NoC destination exactly once.
// Latency: a word pushed at edge N is offered from cycle N+1 (no fall-through).
// Backpressure: fu_oready depends only on FIFO occupancy; the head retires only
//               once every enabled destination has taken it.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   cfg_dest_mask  - per-destination enable (change only while empty)
//   fu_ivalid/fu_in/fu_oready         - result handshake from the functional unit
//   noc_ovalid/noc_out/noc_iready     - per-destination valid/ready, shared data
//   empty          - FIFO holds no words
module ucore_output_channels #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 4,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OUTPUTS-1:0] cfg_dest_mask,
  input  logic                   fu_ivalid,
  input  logic [DATA_WIDTH-1:0]  fu_in,
  output logic                   fu_oready,
  output logic [NUM_OUTPUTS-1:0] noc_ovalid,
  output logic [DATA_WIDTH-1:0]  noc_out,
  input  logic [NUM_OUTPUTS-1:0] noc_iready,
  output logic                   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0]  storage [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [NUM_OUTPUTS-1:0] sent;     // destinations that already took the head
  logic [NUM_OUTPUTS-1:0] accept;
  logic                   has_word;
  logic                   push;
  logic                   done;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign has_word   = (count != '0);
  assign empty      = ~has_word;
  // Registered state only: a full FIFO refuses a push even if it pops this cycle.
  assign fu_oready  = (count != CNT_W'(DEPTH));
  assign push       = fu_ivalid & fu_oready;
  assign noc_out    = storage[rd_ptr];
  assign noc_ovalid = {NUM_OUTPUTS{has_word}} & cfg_dest_mask & ~sent;
  assign accept     = noc_ovalid & noc_iready;
  // Head retires when every destination is served, disabled, or taking it now.
  // An all-zero mask therefore discards the head immediately.
  assign done       = has_word & (&(sent | ~cfg_dest_mask | noc_iready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      sent   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (push) begin
        storage[wr_ptr] <= fu_in;
        wr_ptr          <= inc_ptr(wr_ptr);
      end

      if (done) begin
        rd_ptr <= inc_ptr(rd_ptr);
        sent   <= '0;
      end else begin
        sent <= sent | accept;
      end

      if (push && !done) begin
        count <= count + CNT_W'(1);
      end else if (!push && done) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ucore_output_channels.sv
module tb_ucore_output_channels;

  logic        clk;
  logic        rst;
  logic [3:0]  cfg_dest_mask;
  logic        fu_ivalid;
  logic [31:0] fu_in;
  logic        fu_oready;
  logic [3:0]  noc_ovalid;
  logic [31:0] noc_out;
  logic [3:0]  noc_iready;
  logic        empty;

  ucore_output_channels #(
    .DATA_WIDTH (32),
    .NUM_OUTPUTS(4),
    .DEPTH      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_dest_mask(cfg_dest_mask),
    .fu_ivalid    (fu_ivalid),
    .fu_in        (fu_in),
    .fu_oready    (fu_oready),
    .noc_ovalid   (noc_ovalid),
    .noc_out      (noc_out),
    .noc_iready   (noc_iready),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs applied for one cycle, outputs checked before the edge.
  typedef struct {
    logic        rst;
    logic [3:0]  mask;
    logic        iv;
    logic [31:0] din;
    logic [3:0]  rdy;
    logic        e_ordy;
    logic [3:0]  e_ov;
    logic        e_empty;
    logic        chk_out;
    logic [31:0] e_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] m, input logic iv,
                              input logic [31:0] d, input logic [3:0] rd,
                              input logic eo, input logic [3:0] ev, input logic ee,
                              input logic co, input logic [31:0] eout);
    vec_t v;
    v.rst = r; v.mask = m; v.iv = iv; v.din = d; v.rdy = rd;
    v.e_ordy = eo; v.e_ov = ev; v.e_empty = ee; v.chk_out = co; v.e_out = eout;
    return v;
  endfunction

  // Reference model: a queue of buffered words plus which destinations hold the head.
  logic [31:0] mq[$];
  logic [3:0]  got;
  int          exp_cnt[4];
  int          act_cnt[4];

  task automatic rand_cycle(input logic iv_i, input logic [31:0] d, input logic [3:0] r);
    logic        e_ordy;
    logic        e_empty;
    logic [3:0]  e_ov;
    logic [3:0]  take;
    fu_ivalid  = iv_i;
    fu_in      = d;
    noc_iready = r;
    #1;
    e_ordy  = (mq.size() < 2);
    e_empty = (mq.size() == 0);
    e_ov    = (mq.size() > 0) ? (cfg_dest_mask & ~got) : 4'h0;
    check("rnd.fu_oready", 32'(fu_oready), 32'(e_ordy));
    check("rnd.empty", 32'(empty), 32'(e_empty));
    check("rnd.noc_ovalid", 32'(noc_ovalid), 32'(e_ov));
    if (e_ov != 4'h0) check("rnd.noc_out", noc_out, mq[0]);
    for (int i = 0; i < 4; i++) if (noc_ovalid[i] && r[i]) act_cnt[i]++;
    if (mq.size() > 0) begin
      take = e_ov & r;
      got  = got | take;
      if ((got | ~cfg_dest_mask) == 4'hF) begin
        void'(mq.pop_front());
        got = 4'h0;
      end
    end
    if (iv_i && e_ordy) begin
      mq.push_back(d);
      for (int i = 0; i < 4; i++) if (cfg_dest_mask[i]) exp_cnt[i]++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; cfg_dest_mask = 4'h0; fu_ivalid = 1'b0; fu_in = '0; noc_iready = 4'h0;
    @(posedge clk); #1;

    //               rst mask iv din            rdy    ordy ov     empty chk out
    // reset and single word to all four destinations
    vecs.push_back(mk(1, 4'hF, 0, 32'h0,          4'hF, 1, 4'h0, 1, 1, 32'h0));
    vecs.push_back(mk(0, 4'hF, 1, 32'hA5A5_0001,  4'hF, 1, 4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, 32'h0,          4'hF, 1, 4'hF, 0, 1, 32'hA5A5_0001));
    vecs.push_back(mk(0, 4'hF, 0, 32'h0,          4'hF, 1, 4'h0, 1, 0, 32'h0));
    // staggered ready, dest3 disabled
    vecs.push_back(mk(0, 4'h7, 1, 32'h2222_0002,  4'h0, 1, 4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h1, 1, 4'h7, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h1, 1, 4'h6, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h5, 1, 4'h6, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h5, 1, 4'h2, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h7, 1, 4'h2, 0, 1, 32'h2222_0002));
    vecs.push_back(mk(0, 4'h7, 0, 32'h0,          4'h0, 1, 4'h0, 1, 0, 32'h0));
    // fill to full with no ready, then release
    vecs.push_back(mk(0, 4'hF, 1, 32'h11,         4'h0, 1, 4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 4'hF, 1, 32'h22,         4'h0, 1, 4'hF, 0, 1, 32'h11));
    vecs.push_back(mk(0, 4'hF, 1, 32'h33,         4'h0, 0, 4'hF, 0, 1, 32'h11));
    vecs.push_back(mk(0, 4'hF, 1, 32'h33,         4'hF, 0, 4'hF, 0, 1, 32'h11));
    vecs.push_back(mk(0, 4'hF, 1, 32'h33,         4'hF, 1, 4'hF, 0, 1, 32'h22));
    vecs.push_back(mk(0, 4'hF, 0, 32'h0,          4'hF, 1, 4'hF, 0, 1, 32'h33));
    vecs.push_back(mk(0, 4'hF, 0, 32'h0,          4'h0, 1, 4'h0, 1, 0, 32'h0));
    // all destinations disabled: word discarded without NoC activity
    vecs.push_back(mk(0, 4'h0, 1, 32'hDEAD,       4'h0, 1, 4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 0, 32'h0,          4'hF, 1, 4'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 0, 32'h0,          4'hF, 1, 4'h0, 1, 0, 32'h0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; cfg_dest_mask = vecs[i].mask; fu_ivalid = vecs[i].iv;
      fu_in = vecs[i].din; noc_iready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d.fu_oready", i), 32'(fu_oready), 32'(vecs[i].e_ordy));
      check($sformatf("v%0d.noc_ovalid", i), 32'(noc_ovalid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
      if (vecs[i].chk_out) check($sformatf("v%0d.noc_out", i), noc_out, vecs[i].e_out);
      @(posedge clk); #1;
    end

    // back-to-back push/pop at occupancy one; pointers wrap repeatedly
    cfg_dest_mask = 4'hF; noc_iready = 4'hF; fu_ivalid = 1'b1; fu_in = 32'h1;
    #1; check("b2b.empty0", 32'(empty), 32'h1);
    @(posedge clk); #1;
    for (int k = 2; k <= 6; k++) begin
      fu_in = 32'(k);
      #1;
      check($sformatf("b2b.out%0d", k - 1), noc_out, 32'(k - 1));
      check($sformatf("b2b.ovalid%0d", k - 1), 32'(noc_ovalid), 32'hF);
      check($sformatf("b2b.oready%0d", k - 1), 32'(fu_oready), 32'h1);
      @(posedge clk); #1;
    end
    fu_ivalid = 1'b0;
    #1; check("b2b.out6", noc_out, 32'h6);
    @(posedge clk); #1;
    check("b2b.empty_end", 32'(empty), 32'h1);

    // reset with two words buffered and one destination already served
    noc_iready = 4'h0; fu_ivalid = 1'b1; fu_in = 32'h55;
    @(posedge clk); #1;
    fu_in = 32'h66;
    @(posedge clk); #1;
    fu_ivalid = 1'b0; noc_iready = 4'h2;
    #1; check("rst.full", 32'(fu_oready), 32'h0);
    @(posedge clk); #1;
    noc_iready = 4'h0;
    #1; check("rst.sent_ovalid", 32'(noc_ovalid), 32'hD);
    rst = 1'b1;
    #1;
    check("rst.async_ovalid", 32'(noc_ovalid), 32'h0);
    check("rst.async_empty", 32'(empty), 32'h1);
    check("rst.async_oready", 32'(fu_oready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; fu_ivalid = 1'b1; fu_in = 32'h77;
    @(posedge clk); #1;
    fu_ivalid = 1'b0;
    #1;
    check("rst.new_ovalid", 32'(noc_ovalid), 32'hF);
    check("rst.new_out", noc_out, 32'h77);
    noc_iready = 4'hF;
    @(posedge clk); #1;
    check("rst.new_empty", 32'(empty), 32'h1);

    // randomized traffic against the queue model
    got = 4'h0;
    for (int i = 0; i < 4; i++) begin exp_cnt[i] = 0; act_cnt[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      if (mq.size() == 0 && $urandom_range(0, 7) == 0) cfg_dest_mask = 4'($urandom_range(0, 15));
      rand_cycle($urandom_range(0, 9) < 6, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 6; c++) rand_cycle(1'b0, 32'h0, 4'hF);
    check("drain.model_empty", 32'(mq.size()), 32'h0);
    check("drain.dut_empty", 32'(empty), 32'h1);
    for (int i = 0; i < 4; i++)
      check($sformatf("deliveries.dest%0d", i), 32'(act_cnt[i]), 32'(exp_cnt[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ucore_output_channels.md
Name: ucore_output_channels

Overview:
Output stage of the RipTide ucore. It accepts one result word per handshake from the ucore functional unit, buffers results in a small FIFO, and delivers each word to up to NUM_OUTPUTS NoC destinations using eager-fork semantics. Each enabled destination receives every word exactly once. The FIFO head retires only after all enabled destinations have accepted it. Its NoC-side ports connect to downstream ucores' ucore_input_channels.

Parameters:
DATA_WIDTH, 32, width of each data word
NUM_OUTPUTS, 4, number of NoC destination channels (1..8)
DEPTH, 2, FIFO entries (>=1; pointers wrap explicitly at DEPTH-1, so power of two not required)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cfg_dest_mask  input  NUM_OUTPUTS  per-destination enable; quasi-static configuration
fu_ivalid  input  1  result valid from functional unit
fu_in  input  DATA_WIDTH  result data from functional unit
fu_oready  output  1  FIFO can accept a word
noc_ovalid  output  NUM_OUTPUTS  per-destination valid to NoC
noc_out  output  DATA_WIDTH  head data, shared by all destinations
noc_iready  input  NUM_OUTPUTS  per-destination ready from NoC
empty  output  1  FIFO holds no words

Behaviour:
- Reset (async assert, sync release): count=0, rd_ptr=wr_ptr=0, sent mask=0, storage=0. Resulting outputs: fu_oready=1, noc_ovalid=0, noc_out=0, empty=1.
- Push: fu_ivalid & fu_oready at a rising edge writes fu_in at wr_ptr, then wr_ptr increments with wrap.
- fu_oready = (count != DEPTH), purely from registered state. There is no combinational path from noc_iready to fu_oready, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- Latency: a word pushed at edge N is visible on noc_out and noc_ovalid after edge N (earliest delivery cycle N+1). There is no fall-through.
- noc_out = storage[rd_ptr] whenever count>0; its value is don't-care when empty.
- noc_ovalid[i] = (count>0) & cfg_dest_mask[i] & ~sent[i].
- A destination accepts when noc_ovalid[i] & noc_iready[i].
- done = (count>0) & AND over i of (sent[i] | ~cfg_dest_mask[i] | noc_iready[i]).
- If done: pop. rd_ptr increments with wrap and sent clears to 0.
- Else: sent[i] |= accept[i] for every i.
- A destination accepts each word exactly once. noc_ovalid[i] stays low after its accept until the head changes.
- Valid is never withdrawn before acceptance. Data is stable while any noc_ovalid is high.
- cfg_dest_mask = 0 with count>0: done=1, so the head is discarded in the same cycle. This gives a one-word-per-cycle drain and no NoC activity.
- Simultaneous push and pop (count strictly between 0 and DEPTH): count is unchanged and both pointers advance.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. count saturates neither way, because push is gated by fu_oready and pop by count>0.
- Changing cfg_dest_mask is legal only while empty=1. If changed mid-word, newly disabled destinations are ignored in the done computation and stale sent bits are harmless.
- rst asserted mid-operation: all buffered words are lost, and outputs take their reset values immediately (asynchronously).
- empty = (count==0).

Test Plan:
- Reset, mask=4'b1111, push 0xA5A5_0001; all ready=1 -> noc_ovalid=4'b1111 one cycle after push. Word pops at the next edge, empty=1, and each destination sees it exactly once.
- Staggered ready: mask=4'b0111. Ready bits rise on dest0, dest2, dest1 in cycles 1, 3, 5 -> ovalid drops per destination right after its accept. Pop occurs at the edge of cycle 5 only. Dest3 ovalid stays 0 throughout.
- Backpressure and full, DEPTH=2: push 0x11, 0x22, 0x33 with all ready=0 -> fu_oready=0 after the 2nd push and 0x33 is held off. Releasing ready delivers 0x11 then 0x22 in order, then accepts 0x33.
- Simultaneous push and pop at count=1 over 6 back-to-back words 0x1..0x6 with ready=1 -> one pop per cycle, count stays 1 and pointers wrap. Destinations see the exact sequence 0x1..0x6.
- Mask=0: push 0xDEAD -> noc_ovalid stays 0, empty=1 one cycle later, and no output data is observed.
- Assert rst while count=2 and sent=4'b0010 -> next cycle noc_ovalid=0, empty=1, fu_oready=1. After release, a new push of 0x77 goes to all enabled destinations with no leftover sent state.
